// File: rtl/dmem_port_arbiter.sv
`timescale 1ns/1ps
// dmem_port_arbiter
//   Shares the single-ported data memory between the pipeline MEM stage (CPU)
//   and the external debug/loader port (DBG). One access is in flight at a
//   time. Each access walks IDLE -> ISSUE -> WAIT -> DONE -> IDLE against a
//   fixed-latency memory. The pipeline stays stalled while its access is pending.
//
//   Build option:
//     DMEM_ARB_DBG_PRIO_EN  defined     : DBG wins every tie (fixed priority).
//                           not defined : ties alternate round-robin using last_gnt.
//
//   Owner encoding: DBG = 0, CPU = 1. Because of this, the all-zero reset
//   state leaves last_gnt pointing at DBG, so the first tie goes to the CPU.
module dmem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  // CPU (MEM stage) port
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic [DW-1:0] cpu_rdata_o,
  output logic          cpu_stall_o,
  // debug / loader port
  input  logic          dbg_req_i,
  input  logic          dbg_we_i,
  input  logic [AW-1:0] dbg_addr_i,
  input  logic [DW-1:0] dbg_wdata_i,
  output logic          dbg_gnt_o,
  output logic          dbg_done_o,
  output logic [DW-1:0] dbg_rdata_o,
  // memory side
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  // status
  output logic          busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic       OWN_DBG = 1'b0;
  localparam logic       OWN_CPU = 1'b1;
  // WAIT counter preload: DONE lands exactly MEM_LAT cycles after ISSUE.
  localparam logic [3:0] LAT_M1  = 4'(MEM_LAT - 1);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_gnt_q, last_gnt_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          arb_cpu_win_s;
  logic          done_cpu_s;
  logic          done_dbg_s;

  // Arbitration: pick the port that would win if a grant happened this cycle.
  always_comb begin
    arb_cpu_win_s = 1'b0;
    if (cpu_req_i && dbg_req_i) begin
`ifdef DMEM_ARB_DBG_PRIO_EN
      // The halted-CPU loader path always wins ties; last_gnt is still tracked.
      arb_cpu_win_s = 1'b0;
`else
      // Round-robin: the port that did not win last time gets this grant.
      arb_cpu_win_s = (last_gnt_q == OWN_DBG);
`endif
    end else if (cpu_req_i) begin
      arb_cpu_win_s = 1'b1;
    end else begin
      arb_cpu_win_s = 1'b0;
    end
  end

  // Next-state logic for the access sequencer and its registered memory outputs.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_gnt_d  = last_gnt_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req_i || dbg_req_i) begin
          // Latch the winner's fields now so the memory sees stable registers.
          state_d  = ST_ISSUE;
          mem_en_d = 1'b1;
          if (arb_cpu_win_s) begin
            owner_d     = OWN_CPU;
            last_gnt_d  = OWN_CPU;
            mem_we_d    = cpu_we_i;
            mem_addr_d  = cpu_addr_i;
            mem_wdata_d = cpu_wdata_i;
          end else begin
            owner_d     = OWN_DBG;
            last_gnt_d  = OWN_DBG;
            mem_we_d    = dbg_we_i;
            mem_addr_d  = dbg_addr_i;
            mem_wdata_d = dbg_wdata_i;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        // The strobe is up for this cycle only; start counting the latency.
        cnt_d = LAT_M1;
        if (MEM_LAT == 1) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_DONE: begin
        // Read data is valid this cycle. Always go back to IDLE so a held
        // request is re-arbitrated rather than silently served twice.
        rdata_d = mem_rdata_i;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; a synchronous reset abandons any access in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_DBG;
      last_gnt_q  <= OWN_DBG;
      cnt_q       <= 4'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_gnt_q  <= last_gnt_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // Completion decode and port-facing outputs. These are combinational
  // because the grant, the stall release and the read data must appear in the
  // same cycle as the event they report.
  always_comb begin
    done_cpu_s  = (state_q == ST_DONE) && (owner_q == OWN_CPU);
    done_dbg_s  = (state_q == ST_DONE) && (owner_q == OWN_DBG);
    cpu_rdata_o = done_cpu_s ? mem_rdata_i : rdata_q;
    dbg_rdata_o = done_dbg_s ? mem_rdata_i : rdata_q;
    // A reset in the DONE cycle abandons the access, so it must not release
    // the CPU or report DBG completion.
    cpu_stall_o = cpu_req_i && !(done_cpu_s && !rst_i);
    dbg_done_o  = done_dbg_s && !rst_i;
    dbg_gnt_o   = (state_q == ST_IDLE) && dbg_req_i && !arb_cpu_win_s && !rst_i;
    busy_o      = (state_q != ST_IDLE);
  end

  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
`timescale 1ns/1ps
// Bench for dmem_port_arbiter: instance A uses MEM_LAT=2, instance B uses MEM_LAT=1.
module tb_dmem_port_arbiter;
  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i;
  // instance A signals
  logic        cpu_req_i, cpu_we_i, dbg_req_i, dbg_we_i;
  logic [31:0] cpu_addr_i, cpu_wdata_i, dbg_addr_i, dbg_wdata_i;
  logic [31:0] cpu_rdata_o, dbg_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        cpu_stall_o, dbg_gnt_o, dbg_done_o, mem_en_o, mem_we_o, busy_o;
  // instance B signals
  logic        cpu_req_b, cpu_we_b, dbg_req_b, dbg_we_b;
  logic [31:0] cpu_addr_b, cpu_wdata_b, dbg_addr_b, dbg_wdata_b;
  logic [31:0] cpu_rdata_b, dbg_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
  logic        cpu_stall_b, dbg_gnt_b, dbg_done_b, mem_en_b, mem_we_b, busy_b;

  dmem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT_A)) u_dut (
    .clk_i(clk), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
    .dbg_wdata_i(dbg_wdata_i), .dbg_gnt_o(dbg_gnt_o), .dbg_done_o(dbg_done_o),
    .dbg_rdata_o(dbg_rdata_o), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o)
  );

  dmem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT_B)) u_dut_b (
    .clk_i(clk), .rst_i(rst_i),
    .cpu_req_i(cpu_req_b), .cpu_we_i(cpu_we_b), .cpu_addr_i(cpu_addr_b),
    .cpu_wdata_i(cpu_wdata_b), .cpu_rdata_o(cpu_rdata_b), .cpu_stall_o(cpu_stall_b),
    .dbg_req_i(dbg_req_b), .dbg_we_i(dbg_we_b), .dbg_addr_i(dbg_addr_b),
    .dbg_wdata_i(dbg_wdata_b), .dbg_gnt_o(dbg_gnt_b), .dbg_done_o(dbg_done_b),
    .dbg_rdata_o(dbg_rdata_b), .mem_en_o(mem_en_b), .mem_we_o(mem_we_b),
    .mem_addr_o(mem_addr_b), .mem_wdata_o(mem_wdata_b), .mem_rdata_i(mem_rdata_b),
    .busy_o(busy_b)
  );

  // ---------------- memory model ----------------
  // Read data for an access issued in cycle c is driven during cycle c+LAT.
  // Every other cycle drives a junk pattern, so a capture in the wrong cycle shows up.
  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] pipe_a [0:15];
  logic [31:0] pipe_b [0:15];
  logic [15:0] junk_cnt;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    else return 32'h0;
  endfunction

  initial begin : mem_model
    junk_cnt    = 16'd0;
    mem_rdata_i = 32'h0;
    mem_rdata_b = 32'h0;
    for (int i = 0; i < 16; i++) begin
      pipe_a[i] = 32'h0;
      pipe_b[i] = 32'h0;
    end
    forever begin
      @(negedge clk);
      junk_cnt = junk_cnt + 16'd1;
      for (int i = 15; i > 0; i--) begin
        pipe_a[i] = pipe_a[i-1];
        pipe_b[i] = pipe_b[i-1];
      end
      if (mem_en_o) begin
        pipe_a[0] = mem_rd(mem_addr_o);
        if (mem_we_o) mem_arr[mem_addr_o] = mem_wdata_o;
      end else begin
        pipe_a[0] = {16'hBAD0, junk_cnt};
      end
      if (mem_en_b) pipe_b[0] = mem_rd(mem_addr_b);
      else pipe_b[0] = {16'hBAD1, junk_cnt};
      mem_rdata_i = pipe_a[LAT_A];
      mem_rdata_b = pipe_b[LAT_B];
    end
  end

  // ---------------- scoreboard ----------------
  int          checks;
  int          failures;
  logic [31:0] cpu_exp_q [$];
  logic [31:0] dbg_exp_q [$];
  logic [31:0] addr_exp_q [$];
  int          gnt_cyc_q [$];
  int          rel_cyc_q [$];
  int          done_cyc_q [$];

  task automatic drive_edge();
    @(posedge clk); #1;
  endtask

  task automatic check_edge();
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      drive_edge();
      check_edge();
      checks++;
      if ({busy_o, cpu_stall_o, dbg_gnt_o, dbg_done_o, mem_en_o, mem_we_o} !== 6'b0) begin
        failures++;
        $display("FAIL reset_flags c=%0d got=%b exp=000000", c,
                 {busy_o, cpu_stall_o, dbg_gnt_o, dbg_done_o, mem_en_o, mem_we_o});
      end
      checks++;
      if ((mem_addr_o | mem_wdata_o | cpu_rdata_o | dbg_rdata_o) !== 32'h0) begin
        failures++;
        $display("FAIL reset_buses c=%0d addr=%h wdata=%h crd=%h drd=%h exp=0", c,
                 mem_addr_o, mem_wdata_o, cpu_rdata_o, dbg_rdata_o);
      end
      checks++;
      if (busy_b !== 1'b0) begin
        failures++;
        $display("FAIL reset_busy_b got=%b exp=0", busy_b);
      end
    end
    drive_edge();
    cpu_req_i = 1'b1;
    check_edge();
    checks++;
    if (cpu_stall_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_stall_follows_req got=%b exp=1", cpu_stall_o);
    end
    drive_edge();
    rst_i     = 1'b0;
    cpu_req_i = 1'b0;
  endtask

  task automatic test_cpu_load();
    logic [31:0] e;
    drive_edge();
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h10; cpu_wdata_i = 32'h0;
    cpu_exp_q.push_back(32'hDEADBEEF);
    for (int c = 0; c < 4; c++) begin
      check_edge();
      checks++;
      if ({cpu_stall_o, mem_en_o, busy_o} !== {logic'(c < 3), logic'(c == 1), logic'(c >= 1)}) begin
        failures++;
        $display("FAIL load_timing c=%0d got stall/en/busy=%b%b%b exp=%b%b%b", c,
                 cpu_stall_o, mem_en_o, busy_o, c < 3, c == 1, c >= 1);
      end
      if (c == 1) begin
        checks++;
        if (mem_we_o !== 1'b0 || mem_addr_o !== 32'h10) begin
          failures++;
          $display("FAIL load_issue we=%b addr=%h exp we=0 addr=00000010", mem_we_o, mem_addr_o);
        end
      end
      if (c == 3) begin
        e = (cpu_exp_q.size() > 0) ? cpu_exp_q.pop_front() : 32'hFFFF_FFFF;
        checks++;
        if (cpu_rdata_o !== e) begin
          failures++;
          $display("FAIL load_rdata got=%h exp=%h", cpu_rdata_o, e);
        end
      end
      if (c < 3) drive_edge();
    end
    drive_edge();
    cpu_req_i = 1'b0;
    check_edge();
    checks++;
    if (busy_o !== 1'b0 || cpu_rdata_o !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL load_hold busy=%b rdata=%h exp busy=0 rdata=deadbeef", busy_o, cpu_rdata_o);
    end
  endtask

  task automatic test_cpu_store();
    logic [31:0] e;
    int n;
    drive_edge();
    cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h20; cpu_wdata_i = 32'h55;
    for (int c = 0; c < 4; c++) begin
      check_edge();
      checks++;
      if ({cpu_stall_o, dbg_done_o} !== {logic'(c < 3), 1'b0}) begin
        failures++;
        $display("FAIL store_stall c=%0d got stall/done=%b%b exp=%b0", c, cpu_stall_o, dbg_done_o, c < 3);
      end
      if (c == 1) begin
        checks++;
        if ({mem_en_o, mem_we_o} !== 2'b11 || mem_wdata_o !== 32'h55 || mem_addr_o !== 32'h20) begin
          failures++;
          $display("FAIL store_issue en=%b we=%b addr=%h wdata=%h exp 1 1 00000020 00000055",
                   mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o);
        end
      end
      if (c < 3) drive_edge();
    end
    drive_edge();
    cpu_req_i = 1'b0; cpu_we_i = 1'b0;
    // read the stored word back through the CPU port
    drive_edge();
    cpu_req_i = 1'b1; cpu_addr_i = 32'h20;
    cpu_exp_q.push_back(32'h55);
    n = 0;
    check_edge();
    while (cpu_stall_o && n < 20) begin
      drive_edge();
      check_edge();
      n++;
    end
    checks++;
    if (n != 3) begin
      failures++;
      $display("FAIL readback_latency got=%0d exp=3", n);
    end
    e = (cpu_exp_q.size() > 0) ? cpu_exp_q.pop_front() : 32'hFFFF_FFFF;
    checks++;
    if (cpu_rdata_o !== e) begin
      failures++;
      $display("FAIL readback_rdata got=%h exp=%h", cpu_rdata_o, e);
    end
    drive_edge();
    cpu_req_i = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [31:0] e;
    int ec;
    drive_edge(); rst_i = 1'b1;
    drive_edge(); rst_i = 1'b0;
`ifdef DMEM_ARB_DBG_PRIO_EN
    addr_exp_q = '{32'h80, 32'h80, 32'h80, 32'h80};
    gnt_cyc_q  = '{0, 4, 8, 12};
    done_cyc_q = '{3, 7, 11, 15};
    rel_cyc_q  = {};
`else
    addr_exp_q = '{32'h40, 32'h80, 32'h40, 32'h80};
    gnt_cyc_q  = '{4, 12};
    done_cyc_q = '{7, 15};
    rel_cyc_q  = '{3, 11};
`endif
    drive_edge();
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h40;
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'h80;
    for (int c = 0; c < 16; c++) begin
      check_edge();
      if (mem_en_o) begin
        e = (addr_exp_q.size() > 0) ? addr_exp_q.pop_front() : 32'hFFFF_FFFF;
        checks++;
        if (mem_addr_o !== e) begin
          failures++;
          $display("FAIL rr_order c=%0d addr=%h exp=%h", c, mem_addr_o, e);
        end
      end
      if (dbg_gnt_o) begin
        ec = (gnt_cyc_q.size() > 0) ? gnt_cyc_q.pop_front() : -1;
        checks++;
        if (c != ec) begin
          failures++;
          $display("FAIL rr_dbg_gnt_cycle got=%0d exp=%0d", c, ec);
        end
      end
      if (dbg_done_o) begin
        ec = (done_cyc_q.size() > 0) ? done_cyc_q.pop_front() : -1;
        checks++;
        if (c != ec) begin
          failures++;
          $display("FAIL rr_dbg_done_cycle got=%0d exp=%0d", c, ec);
        end
      end
      if (!cpu_stall_o) begin
        ec = (rel_cyc_q.size() > 0) ? rel_cyc_q.pop_front() : -1;
        checks++;
        if (c != ec) begin
          failures++;
          $display("FAIL rr_cpu_release_cycle got=%0d exp=%0d", c, ec);
        end
      end
      drive_edge();
    end
    cpu_req_i = 1'b0;
    dbg_req_i = 1'b0;
    checks++;
    if ((addr_exp_q.size() + gnt_cyc_q.size() + done_cyc_q.size() + rel_cyc_q.size()) != 0) begin
      failures++;
      $display("FAIL rr_missing_events issues=%0d gnts=%0d dones=%0d releases=%0d exp all 0",
               addr_exp_q.size(), gnt_cyc_q.size(), done_cyc_q.size(), rel_cyc_q.size());
    end
  endtask

  task automatic test_cpu_waits_for_dbg();
    logic [31:0] e;
    drive_edge();
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'h10;
    dbg_exp_q.push_back(32'hDEADBEEF);
    for (int c = 0; c < 9; c++) begin
      check_edge();
      checks++;
      if ({dbg_gnt_o, dbg_done_o} !== {logic'(c == 0), logic'(c == 3)}) begin
        failures++;
        $display("FAIL wait_dbg_handshake c=%0d got gnt/done=%b%b exp=%b%b", c,
                 dbg_gnt_o, dbg_done_o, c == 0, c == 3);
      end
      if (c >= 1) begin
        checks++;
        if (cpu_stall_o !== logic'(c >= 1 && c < 7 || c == 8 && cpu_req_i)) begin
          failures++;
          $display("FAIL wait_cpu_stall c=%0d got=%b exp=%b", c, cpu_stall_o, c < 7);
        end
      end
      if (c == 3) begin
        e = (dbg_exp_q.size() > 0) ? dbg_exp_q.pop_front() : 32'hFFFF_FFFF;
        checks++;
        if (dbg_rdata_o !== e) begin
          failures++;
          $display("FAIL wait_dbg_rdata got=%h exp=%h", dbg_rdata_o, e);
        end
      end
      if (c == 5) begin
        checks++;
        if (mem_en_o !== 1'b1 || mem_addr_o !== 32'h20) begin
          failures++;
          $display("FAIL wait_cpu_issue en=%b addr=%h exp en=1 addr=00000020", mem_en_o, mem_addr_o);
        end
      end
      if (c == 7) begin
        e = (cpu_exp_q.size() > 0) ? cpu_exp_q.pop_front() : 32'hFFFF_FFFF;
        checks++;
        if (cpu_rdata_o !== e) begin
          failures++;
          $display("FAIL wait_cpu_rdata got=%h exp=%h", cpu_rdata_o, e);
        end
      end
      drive_edge();
      if (c == 0) begin
        dbg_req_i = 1'b0;
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h20;
        cpu_exp_q.push_back(32'h55);
      end
      if (c == 7) cpu_req_i = 1'b0;
    end
  endtask

  task automatic test_flush();
    drive_edge();
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h10;
    for (int c = 0; c < 7; c++) begin
      check_edge();
      checks++;
      if ({cpu_stall_o, mem_en_o, busy_o, dbg_done_o} !==
          {logic'(c < 2), logic'(c == 1), logic'(c >= 1 && c <= 3), 1'b0}) begin
        failures++;
        $display("FAIL flush c=%0d got stall/en/busy/done=%b%b%b%b exp=%b%b%b0", c,
                 cpu_stall_o, mem_en_o, busy_o, dbg_done_o, c < 2, c == 1, c >= 1 && c <= 3);
      end
      drive_edge();
      if (c == 1) cpu_req_i = 1'b0;
    end
  endtask

  task automatic test_rst_abort();
    drive_edge();
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'h10;
    check_edge();
    checks++;
    if (dbg_gnt_o !== 1'b1) begin
      failures++;
      $display("FAIL abort_gnt got=%b exp=1", dbg_gnt_o);
    end
    drive_edge();
    dbg_req_i = 1'b0;
    check_edge();
    checks++;
    if ({mem_en_o, busy_o} !== 2'b11) begin
      failures++;
      $display("FAIL abort_issue got en/busy=%b%b exp=11", mem_en_o, busy_o);
    end
    drive_edge();
    rst_i = 1'b1;
    check_edge();
    drive_edge();
    rst_i = 1'b0;
    for (int c = 3; c < 6; c++) begin
      check_edge();
      checks++;
      if ({busy_o, dbg_done_o, mem_en_o} !== 3'b000 || dbg_rdata_o !== 32'h0) begin
        failures++;
        $display("FAIL abort_after c=%0d got busy/done/en=%b%b%b drd=%h exp=000 00000000", c,
                 busy_o, dbg_done_o, mem_en_o, dbg_rdata_o);
      end
      drive_edge();
    end
  endtask

  task automatic test_lat1();
    logic [31:0] e;
    drive_edge();
    cpu_req_b = 1'b1; cpu_we_b = 1'b0; cpu_addr_b = 32'h10;
    cpu_exp_q.push_back(32'hDEADBEEF);
    for (int c = 0; c < 4; c++) begin
      check_edge();
      checks++;
      if ({cpu_stall_b, mem_en_b, busy_b} !==
          {logic'(c < 2), logic'(c == 1), logic'(c == 1 || c == 2)}) begin
        failures++;
        $display("FAIL lat1_timing c=%0d got stall/en/busy=%b%b%b exp=%b%b%b", c,
                 cpu_stall_b, mem_en_b, busy_b, c < 2, c == 1, c == 1 || c == 2);
      end
      if (c == 2) begin
        e = (cpu_exp_q.size() > 0) ? cpu_exp_q.pop_front() : 32'hFFFF_FFFF;
        checks++;
        if (cpu_rdata_b !== e) begin
          failures++;
          $display("FAIL lat1_rdata got=%h exp=%h", cpu_rdata_b, e);
        end
      end
      drive_edge();
      if (c == 2) cpu_req_b = 1'b0;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    checks = 0; failures = 0;
    mem_arr[32'h10] = 32'hDEADBEEF;
    rst_i = 1'b1;
    cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = 32'h0; cpu_wdata_i = 32'h0;
    dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = 32'h0; dbg_wdata_i = 32'h0;
    cpu_req_b = 1'b0; cpu_we_b = 1'b0; cpu_addr_b = 32'h0; cpu_wdata_b = 32'h0;
    dbg_req_b = 1'b0; dbg_we_b = 1'b0; dbg_addr_b = 32'h0; dbg_wdata_b = 32'h0;
    test_reset();
    test_cpu_load();
    test_cpu_store();
    test_round_robin();
    test_cpu_waits_for_dbg();
    test_flush();
    test_rst_abort();
    test_lat1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
